// File: rtl/k12a_acu_serial.sv
// k12a_acu_serial: slice-serial base+offset address unit with start/busy/done
// handshake, held result, wrap flag and tri-state drive onto the address bus.
//
// Ports:
//   clock, reset_n            clock, synchronous active-low reset
//   start                     request a computation (sampled on rising edge)
//   input1_sel                base select: 0=PC 1=CD 2=SP 3=IX
//   input2_sel                offset: 0=REL 1=+1 2=+2 3=-1 4=-2 5..7=0
//   pc, cd, sp, ix            base candidates
//   inst                      instruction word, REL = inst[REL_WIDTH-1:0]
//   busy, done                registered handshake outputs
//   wrapped, result           last completed computation
//   acu_load_n, addr_bus      active-low bus enable, shared address bus
module k12a_acu_serial #(
  parameter int ADDR_WIDTH  = 16,
  parameter int SLICE_WIDTH = 8,
  parameter int REL_WIDTH   = 11
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            input1_sel,
  input  logic [2:0]            input2_sel,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] cd,
  input  logic [ADDR_WIDTH-1:0] sp,
  input  logic [ADDR_WIDTH-1:0] ix,
  input  logic [15:0]           inst,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [ADDR_WIDTH-1:0] result,
  input  logic                  acu_load_n,
  inout  wire  [ADDR_WIDTH-1:0] addr_bus
);

  localparam int N   = ADDR_WIDTH / SLICE_WIDTH;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;
  localparam int SHW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   op_a_q, op_a_d;
  logic [ADDR_WIDTH-1:0]   op_b_q, op_b_d;
  logic [ADDR_WIDTH-1:0]   acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]   result_q, result_d;
  logic [SW-1:0]           slice_q, slice_d;
  logic                    carry_q, carry_d;
  logic                    wrapped_q, wrapped_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [ADDR_WIDTH-1:0]   base_sel;
  logic [ADDR_WIDTH-1:0]   off_sel;
  logic [ADDR_WIDTH-1:0]   rel_ext;
  logic signed [REL_WIDTH-1:0] rel;

  logic [SHW-1:0]          shamt;
  logic [ADDR_WIDTH-1:0]   a_sh, b_sh;
  logic [SLICE_WIDTH-1:0]  a_sl, b_sl;
  logic [SLICE_WIDTH:0]    sum_sl;
  logic [ADDR_WIDTH-1:0]   sl_mask;
  logic [ADDR_WIDTH-1:0]   acc_ins;
  logic                    last_slice;

  // Upper instruction bits are not part of the relative field.
  if (REL_WIDTH < 16) begin : g_unused
    logic unused_inst;
    assign unused_inst = ^inst[15:REL_WIDTH];
  end

  assign rel     = inst[REL_WIDTH-1:0];
  assign rel_ext = ADDR_WIDTH'(rel);

  always_comb begin
    base_sel = pc;
    unique case (input1_sel)
      2'd0: base_sel = pc;
      2'd1: base_sel = cd;
      2'd2: base_sel = sp;
      2'd3: base_sel = ix;
    endcase
  end

  always_comb begin
    off_sel = '0;
    case (input2_sel)
      3'd0:    off_sel = rel_ext;
      3'd1:    off_sel = ADDR_WIDTH'(1);
      3'd2:    off_sel = ADDR_WIDTH'(2);
      3'd3:    off_sel = '1;
      3'd4:    off_sel = ~ADDR_WIDTH'(1);
      default: off_sel = '0;
    endcase
  end

  // Current slice of each operand, selected by shifting so the
  // index width never depends on the parameter set.
  assign shamt  = SHW'(slice_q) * SHW'(SLICE_WIDTH);
  assign a_sh   = op_a_q >> shamt;
  assign b_sh   = op_b_q >> shamt;
  assign a_sl   = a_sh[SLICE_WIDTH-1:0];
  assign b_sl   = b_sh[SLICE_WIDTH-1:0];
  assign sum_sl = {1'b0, a_sl} + {1'b0, b_sl}
                + {{SLICE_WIDTH{1'b0}}, carry_q};

  assign sl_mask = ADDR_WIDTH'({SLICE_WIDTH{1'b1}}) << shamt;
  assign acc_ins = (acc_q & ~sl_mask)
                 | (ADDR_WIDTH'(sum_sl[SLICE_WIDTH-1:0]) << shamt);

  assign last_slice = (slice_q == SW'(N - 1));

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    slice_d   = slice_q;
    result_d  = result_q;
    wrapped_d = wrapped_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_a_d  = base_sel;
          op_b_d  = off_sel;
          carry_d = 1'b0;
          slice_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = acc_ins;
        carry_d = sum_sl[SLICE_WIDTH];
        if (last_slice) begin
          // Final slice goes straight into result so no partial
          // sum is ever visible.
          result_d  = acc_ins;
          wrapped_d = op_b_q[ADDR_WIDTH-1] ^ sum_sl[SLICE_WIDTH];
          state_d   = S_DONE;
        end else begin
          slice_d = slice_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ADD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      slice_q   <= '0;
      result_q  <= '0;
      wrapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      slice_q   <= slice_d;
      result_q  <= result_d;
      wrapped_q <= wrapped_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wrapped = wrapped_q;
  assign result  = result_q;

  assign addr_bus = acu_load_n ? {ADDR_WIDTH{1'bz}} : result_q;

endmodule

// File: tb/tb_k12a_acu_serial.sv
// tb_k12a_acu_serial: directed test of k12a_acu_serial at 16/8 and 24/8
// address/slice widths.
module tb_k12a_acu_serial;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, load_n;
  logic [1:0]  s1;
  logic [2:0]  s2;
  logic [15:0] pc, cd, sp, ix, inst;
  logic        busy, done, wrapped;
  logic [15:0] result;
  wire  [15:0] addr_bus;

  // Other bus agent: drives a marker value while the unit is disabled.
  assign addr_bus = load_n ? 16'hA5A5 : 16'hzzzz;

  logic        start24, load24_n;
  logic [1:0]  s1_24;
  logic [2:0]  s2_24;
  logic [23:0] pc24, cd24, sp24, ix24;
  logic        busy24, done24, wrapped24;
  logic [23:0] result24;
  wire  [23:0] addr_bus24;

  k12a_acu_serial u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .input1_sel(s1), .input2_sel(s2),
    .pc(pc), .cd(cd), .sp(sp), .ix(ix), .inst(inst),
    .busy(busy), .done(done), .wrapped(wrapped), .result(result),
    .acu_load_n(load_n), .addr_bus(addr_bus)
  );

  k12a_acu_serial #(.ADDR_WIDTH(24), .SLICE_WIDTH(8), .REL_WIDTH(11)) u_dut24 (
    .clock(clock), .reset_n(reset_n), .start(start24),
    .input1_sel(s1_24), .input2_sel(s2_24),
    .pc(pc24), .cd(cd24), .sp(sp24), .ix(ix24), .inst(inst),
    .busy(busy24), .done(done24), .wrapped(wrapped24), .result(result24),
    .acu_load_n(load24_n), .addr_bus(addr_bus24)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run16(input string tag, input logic [1:0] a,
                       input logic [2:0] b, input logic [15:0] exp_r,
                       input logic exp_w);
    int cnt;
    int both;
    s1 = a;
    s2 = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 1;
    both = 0;
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    while (!done && cnt < 10) begin
      tick();
      cnt++;
      if (busy && done) both++;
    end
    check({tag, ".lat"}, 32'(cnt), 32'd3);
    check({tag, ".bd"}, 32'(both), 32'd0);
    check({tag, ".res"}, 32'(result), 32'(exp_r));
    check({tag, ".wrap"}, 32'(wrapped), 32'(exp_w));
  endtask

  initial begin
    int cnt;
    int ndone;
    reset_n = 1'b0; start = 1'b0; load_n = 1'b1;
    s1 = '0; s2 = '0; pc = '0; cd = '0; sp = '0; ix = '0; inst = '0;
    start24 = 1'b0; load24_n = 1'b1; s1_24 = '0; s2_24 = '0;
    pc24 = '0; cd24 = '0; sp24 = '0; ix24 = '0;

    tick(); tick();
    check("rst.res", 32'(result), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.wrap", 32'(wrapped), 32'h0);
    check("rst.bus", 32'(addr_bus), 32'hA5A5);
    reset_n = 1'b1;
    tick();

    // PC-relative, REL = -1
    pc = 16'h1234; inst = 16'h07FF;
    run16("pcrel", 2'd0, 3'd0, 16'h1233, 1'b0);
    tick();
    check("pcrel.pulse", 32'(done), 32'h0);
    load_n = 1'b0; #1;
    check("bus.drive", 32'(addr_bus), 32'h1233);
    load_n = 1'b1; #1;
    check("bus.float", 32'(addr_bus), 32'hA5A5);

    // Stack wrap both directions
    sp = 16'h0000;
    run16("spdec", 2'd2, 3'd3, 16'hFFFF, 1'b1);
    tick();
    sp = 16'hFFFF;
    run16("spinc2", 2'd2, 3'd2, 16'h0001, 1'b1);
    tick();

    // Positive REL across top, zero and reserved offsets, -2
    pc = 16'hFFF0; inst = 16'h0010;
    run16("relwrap", 2'd0, 3'd0, 16'h0000, 1'b1);
    tick();
    ix = 16'hBEEF;
    run16("zero", 2'd3, 3'd5, 16'hBEEF, 1'b0);
    tick();
    run16("rsvd7", 2'd3, 3'd7, 16'hBEEF, 1'b0);
    tick();
    sp = 16'h0100;
    run16("spdec2", 2'd2, 3'd4, 16'h00FE, 1'b0);
    tick();

    // Operand capture, start ignored during ADD
    cd = 16'h00FF; s1 = 2'd1; s2 = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b1; cd = 16'h5555;
    tick();
    start = 1'b0;
    check("cap.busy1", 32'(busy), 32'h1);
    check("cap.done1", 32'(done), 32'h0);
    tick();
    check("cap.done", 32'(done), 32'h1);
    check("cap.res", 32'(result), 32'h0100);
    check("cap.wrap", 32'(wrapped), 32'h0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("cap.single", 32'(ndone), 32'h0);

    // Back-to-back: second start lands in the DONE cycle
    pc = 16'h0010; inst = 16'h0005;
    run16("b2b.a", 2'd0, 3'd0, 16'h0015, 1'b0);
    sp = 16'h8000;
    run16("b2b.b", 2'd2, 3'd1, 16'h8001, 1'b0);
    tick();

    // Reset abort mid-ADD
    pc = 16'h4000; s1 = 2'd0; s2 = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort.busy", 32'(busy), 32'h0);
    check("abort.done", 32'(done), 32'h0);
    check("abort.res", 32'(result), 32'h0);
    check("abort.wrap", 32'(wrapped), 32'h0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort.nodone", 32'(ndone), 32'h0);

    // 24-bit instance, N = 3
    ix24 = 24'h00FFFF; s1_24 = 2'd3; s2_24 = 3'd1;
    start24 = 1'b1;
    tick();
    start24 = 1'b0;
    cnt = 1;
    while (!done24 && cnt < 12) begin
      tick();
      cnt++;
    end
    check("w24.lat", 32'(cnt), 32'd4);
    check("w24.res", 32'(result24), 32'h010000);
    check("w24.wrap", 32'(wrapped24), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
